// File: rtl/bbpd_dlf_pkg.sv
// Shared types, default parameters and arithmetic helpers for the CDR
// bang-bang loop filter.
package bbpd_dlf_pkg;

  typedef enum logic {
    ACQ   = 1'b0,
    TRACK = 1'b1
  } dlf_state_e;

  localparam int unsigned NBIT_DEF       = 14;
  localparam int unsigned NFRAC_DEF      = 10;
  localparam int unsigned DECIM_DEF      = 8;
  localparam int unsigned KP_DEF         = 4;
  localparam int unsigned KI_ACQ_DEF     = 4;
  localparam int unsigned KI_TRK_DEF     = 8;
  localparam int unsigned LOCK_CNT_DEF   = 16;
  localparam int unsigned UNLOCK_CNT_DEF = 4;

  // Wide signed type so integrator and code sums never overflow before clamping
  localparam int unsigned ARITH_W = 40;
  typedef logic signed [ARITH_W-1:0] arith_t;

  // Vote range is [-DECIM, +DECIM], which needs log2(DECIM)+2 signed bits
  function automatic int unsigned vote_width(input int unsigned decim);
    return $clog2(decim) + 2;
  endfunction

  localparam int unsigned VOTE_W = vote_width(DECIM_DEF);

  // a + b clamped to [0, hi]
  function automatic arith_t sat_add(input arith_t a, input arith_t b, input arith_t hi);
    arith_t s;
    s = a + b;
    if (s < 0) begin
      return '0;
    end else if (s > hi) begin
      return hi;
    end
    return s;
  endfunction

endpackage

// File: rtl/bbpd_vote_decimator.sv
// Accumulates enabled early/late decisions and emits one signed vote per
// DECIM-sample window, with a single-cycle done strobe.
module bbpd_vote_decimator
  import bbpd_dlf_pkg::*;
#(
  parameter int unsigned DECIM  = DECIM_DEF,
  parameter int unsigned W_VOTE = VOTE_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_en,
  input  logic                     i_up,
  input  logic                     i_dn,
  output logic signed [W_VOTE-1:0] o_votes,
  output logic                     o_window_done
);

  localparam int unsigned W_CNT = $clog2(DECIM);

  logic [W_CNT-1:0]         r_cnt;
  logic signed [W_VOTE-1:0] r_acc;
  logic signed [W_VOTE-1:0] r_votes;
  logic                     r_done;

  logic signed [W_VOTE-1:0] w_e;
  logic signed [W_VOTE-1:0] w_sum;
  logic                     w_last;

  // Both-high and both-low decisions carry no information
  always_comb begin
    w_e = '0;
    if (i_up && !i_dn) begin
      w_e = W_VOTE'(1);
    end else if (i_dn && !i_up) begin
      w_e = W_VOTE'(-1);
    end
    w_sum  = r_acc + w_e;
    w_last = (r_cnt == W_CNT'(DECIM - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_votes <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_en) begin
        if (w_last) begin
          r_votes <= w_sum;
          r_done  <= 1'b1;
          r_acc   <= '0;
          r_cnt   <= '0;
        end else begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + W_CNT'(1);
        end
      end
    end
  end

  assign o_votes       = r_votes;
  assign o_window_done = r_done;

endmodule

// File: rtl/bbpd_loop_filter.sv
// Proportional-integral CDR loop filter: window votes drive a saturating
// integrator plus proportional kick, with ACQ/TRACK gear shifting.
module bbpd_loop_filter
  import bbpd_dlf_pkg::*;
#(
  parameter int unsigned Nbit       = NBIT_DEF,
  parameter int unsigned Nfrac      = NFRAC_DEF,
  parameter int unsigned DECIM      = DECIM_DEF,
  parameter int unsigned KP         = KP_DEF,
  parameter int unsigned KI_ACQ     = KI_ACQ_DEF,
  parameter int unsigned KI_TRK     = KI_TRK_DEF,
  parameter int unsigned CODE_INIT  = 2 ** (Nbit - 1),
  parameter int unsigned LOCK_CNT   = LOCK_CNT_DEF,
  parameter int unsigned UNLOCK_CNT = UNLOCK_CNT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            up,
  input  logic            dn,
  output logic [Nbit-1:0] code,
  output logic            locked,
  output logic            sat
);

  localparam int unsigned W_VOTE = vote_width(DECIM);
  localparam int unsigned W_INT  = Nbit + Nfrac;
  localparam int unsigned W_QCNT = $clog2(LOCK_CNT + 1);
  localparam int unsigned W_SCNT = $clog2(UNLOCK_CNT + 1);
  localparam arith_t      INT_MAX  = (arith_t'(1) <<< W_INT) - arith_t'(1);
  localparam arith_t      CODE_MAX = (arith_t'(1) <<< Nbit) - arith_t'(1);

  logic signed [W_VOTE-1:0] w_votes;
  logic                     w_done;

  logic [W_INT-1:0]  r_integ;
  logic [Nbit-1:0]   r_code;
  logic              r_sat;
  logic              r_locked;
  dlf_state_e        r_state;
  logic [W_QCNT-1:0] r_qcnt;
  logic [W_SCNT-1:0] r_scnt;

  logic [W_INT-1:0]  w_integ_nxt;
  logic [Nbit-1:0]   w_code_nxt;
  logic              w_sat_nxt;
  dlf_state_e        w_state_nxt;
  logic [W_QCNT-1:0] w_qcnt_nxt;
  logic [W_SCNT-1:0] w_scnt_nxt;

  int unsigned       w_ki;
  arith_t            w_step;
  arith_t            w_prop;
  logic [W_VOTE-1:0] w_abs;
  logic              w_quiet;
  logic              w_slew;
  logic [W_INT-1:0]  w_integ_sum;
  logic [Nbit-1:0]   w_code_sum;

  bbpd_vote_decimator #(
    .DECIM  (DECIM),
    .W_VOTE (W_VOTE)
  ) u_decim (
    .clk           (clk),
    .rst           (rst),
    .i_en          (en),
    .i_up          (up),
    .i_dn          (dn),
    .o_votes       (w_votes),
    .o_window_done (w_done)
  );

  // Integral gain follows the state held before this window's FSM update
  always_comb begin
    w_integ_nxt = r_integ;
    w_code_nxt  = r_code;
    w_sat_nxt   = r_sat;
    w_state_nxt = r_state;
    w_qcnt_nxt  = r_qcnt;
    w_scnt_nxt  = r_scnt;

    w_ki   = (r_state == TRACK) ? KI_TRK : KI_ACQ;
    w_step = arith_t'(w_votes) <<< (Nfrac - w_ki);
    w_prop = '0;
    if (w_votes > 0) begin
      w_prop = arith_t'(KP);
    end else if (w_votes < 0) begin
      w_prop = -arith_t'(KP);
    end
    w_abs   = (w_votes < 0) ? W_VOTE'(-w_votes) : W_VOTE'(w_votes);
    w_quiet = (w_abs <= W_VOTE'(DECIM / 2));
    w_slew  = (w_abs == W_VOTE'(DECIM));

    w_integ_sum = W_INT'(sat_add(arith_t'(r_integ), w_step, INT_MAX));
    w_code_sum  = Nbit'(sat_add(arith_t'(w_integ_sum[W_INT-1:Nfrac]), w_prop, CODE_MAX));

    if (w_done) begin
      w_integ_nxt = w_integ_sum;
      w_code_nxt  = w_code_sum;
      w_sat_nxt   = (w_code_sum == '0) || (w_code_sum == '1);

      case (r_state)
        ACQ: begin
          w_scnt_nxt = '0;
          if (!w_quiet) begin
            w_qcnt_nxt = '0;
          end else if (r_qcnt == W_QCNT'(LOCK_CNT - 1)) begin
            w_state_nxt = TRACK;
            w_qcnt_nxt  = '0;
          end else begin
            w_qcnt_nxt = r_qcnt + W_QCNT'(1);
          end
        end
        TRACK: begin
          w_qcnt_nxt = '0;
          if (!w_slew) begin
            w_scnt_nxt = '0;
          end else if (r_scnt == W_SCNT'(UNLOCK_CNT - 1)) begin
            w_state_nxt = ACQ;
            w_scnt_nxt  = '0;
          end else begin
            w_scnt_nxt = r_scnt + W_SCNT'(1);
          end
        end
        default: begin
          w_state_nxt = ACQ;
          w_qcnt_nxt  = '0;
          w_scnt_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_integ  <= W_INT'(CODE_INIT) << Nfrac;
      r_code   <= Nbit'(CODE_INIT);
      r_sat    <= 1'b0;
      r_locked <= 1'b0;
      r_state  <= ACQ;
      r_qcnt   <= '0;
      r_scnt   <= '0;
    end else begin
      r_integ  <= w_integ_nxt;
      r_code   <= w_code_nxt;
      r_sat    <= w_sat_nxt;
      r_locked <= (w_state_nxt == TRACK);
      r_state  <= w_state_nxt;
      r_qcnt   <= w_qcnt_nxt;
      r_scnt   <= w_scnt_nxt;
    end
  end

  assign code   = r_code;
  assign locked = r_locked;
  assign sat    = r_sat;

endmodule

// File: tb/tb_bbpd_loop_filter.sv
// Randomised and directed bench for bbpd_loop_filter: two instances (mid-scale
// and near-top reset code) checked every cycle against a behavioural model.
module tb_bbpd_loop_filter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic        up  = 1'b0;
  logic        dn  = 1'b0;
  logic [13:0] code0, code1;
  logic        locked0, locked1, sat0, sat1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bbpd_loop_filter u_mid (
    .clk(clk), .rst(rst), .en(en), .up(up), .dn(dn),
    .code(code0), .locked(locked0), .sat(sat0)
  );

  bbpd_loop_filter #(.CODE_INIT(16376)) u_hi (
    .clk(clk), .rst(rst), .en(en), .up(up), .dn(dn),
    .code(code1), .locked(locked1), .sat(sat1)
  );

  // Behavioural model: window sums, fixed-point integrator, gear-shift counters
  longint m_init [2] = '{8192, 16376};
  longint m_i    [2];
  longint m_code [2];
  bit     m_trk  [2];
  bit     m_lock [2];
  bit     m_sat  [2];
  int     m_q    [2];
  int     m_s    [2];
  int     m_sum, m_n, m_pv;
  bit     m_pend;
  longint t_ki, t_c, t_a;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_i[k] = m_init[k] * 1024;
        m_code[k] = m_init[k];
        m_trk[k] = 0; m_lock[k] = 0; m_sat[k] = 0;
        m_q[k] = 0; m_s[k] = 0;
      end else if (m_pend) begin
        t_ki = m_trk[k] ? 8 : 4;
        m_i[k] = m_i[k] + longint'(m_pv) * (longint'(1) << (10 - t_ki));
        if (m_i[k] < 0) m_i[k] = 0;
        if (m_i[k] > 16777215) m_i[k] = 16777215;
        t_c = m_i[k] / 1024 + ((m_pv > 0) ? 4 : (m_pv < 0) ? -4 : 0);
        if (t_c < 0) t_c = 0;
        if (t_c > 16383) t_c = 16383;
        m_code[k] = t_c;
        m_sat[k] = (t_c == 0) || (t_c == 16383);
        t_a = (m_pv < 0) ? -m_pv : m_pv;
        if (!m_trk[k]) begin
          m_q[k] = (t_a <= 4) ? m_q[k] + 1 : 0;
          if (m_q[k] == 16) begin m_trk[k] = 1; m_q[k] = 0; m_s[k] = 0; end
        end else begin
          m_s[k] = (t_a == 8) ? m_s[k] + 1 : 0;
          if (m_s[k] == 4) begin m_trk[k] = 0; m_q[k] = 0; m_s[k] = 0; end
        end
        m_lock[k] = m_trk[k];
      end
    end
    if (rst) begin
      m_sum = 0; m_n = 0; m_pend = 0;
    end else begin
      m_pend = 0;
      if (en) begin
        m_sum += (up && !dn) ? 1 : (dn && !up) ? -1 : 0;
        m_n++;
        if (m_n == 8) begin m_pend = 1; m_pv = m_sum; m_sum = 0; m_n = 0; end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, then compare every output against the model
  task automatic cyc(input logic e, input logic u, input logic d);
    en = e; up = u; dn = d;
    @(posedge clk);
    #1;
    chk("code0", 64'(code0), 64'(m_code[0]));
    chk("locked0", 64'(locked0), 64'(m_lock[0]));
    chk("sat0", 64'(sat0), 64'(m_sat[0]));
    chk("code1", 64'(code1), 64'(m_code[1]));
    chk("locked1", 64'(locked1), 64'(m_lock[1]));
    chk("sat1", 64'(sat1), 64'(m_sat[1]));
  endtask

  // mode 0 all up, 1 all dn, 2 alternating up/dn, 3 both high
  task automatic run_win(input int mode);
    for (int i = 0; i < 8; i++) begin
      case (mode)
        0: cyc(1'b1, 1'b1, 1'b0);
        1: cyc(1'b1, 1'b0, 1'b1);
        2: cyc(1'b1, (i % 2) == 0, (i % 2) == 1);
        default: cyc(1'b1, 1'b1, 1'b1);
      endcase
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  int mode;
  logic r_e, r_u, r_d;

  initial begin
    // Reset values and hold with en low
    do_reset();
    chk("rst_code", 64'(code0), 64'd8192);
    chk("rst_locked", 64'(locked0), 64'd0);
    chk("rst_sat", 64'(sat0), 64'd0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    chk("hold_code", 64'(code0), 64'd8192);

    // Step: two-edge latency, then +4 proportional and +0.5 LSB integral
    run_win(0);
    chk("step_latency", 64'(code0), 64'd8192);
    cyc(1'b0, 1'b0, 1'b0);
    chk("step1", 64'(code0), 64'd8196);
    run_win(0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("step2", 64'(code0), 64'd8197);

    // Null input patterns
    do_reset();
    run_win(3); run_win(3); run_win(2); run_win(2);
    cyc(1'b0, 1'b0, 1'b0);
    chk("null_code", 64'(code0), 64'd8192);

    // Lock after 16 quiet windows, unlock after 4 slew windows
    do_reset();
    for (int w = 0; w < 16; w++) begin
      run_win(2);
      cyc(1'b0, 1'b0, 1'b0);
      chk("lock_rise", 64'(locked0), 64'(w == 15));
    end
    for (int w = 0; w < 4; w++) begin
      run_win(0);
      cyc(1'b0, 1'b0, 1'b0);
      chk("lock_fall", 64'(locked0), 64'(w < 3));
    end
    chk("track_code", 64'(code0), 64'd8196);
    run_win(0); cyc(1'b0, 1'b0, 1'b0);
    run_win(0); cyc(1'b0, 1'b0, 1'b0);
    chk("acq_gain", 64'(code0), 64'd8197);

    // Saturation at the top rail and recovery on the first reversed window
    do_reset();
    for (int w = 0; w < 60 && code1 != 14'd16383; w++) begin
      run_win(0);
      cyc(1'b0, 1'b0, 1'b0);
    end
    chk("sat_code", 64'(code1), 64'd16383);
    chk("sat_flag", 64'(sat1), 64'd1);
    for (int w = 0; w < 20; w++) begin
      run_win(0);
      cyc(1'b0, 1'b0, 1'b0);
    end
    run_win(1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("unsat_code", 64'(code1), 64'd16379);
    chk("unsat_flag", 64'(sat1), 64'd0);

    // en gap inside a window
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0);
    chk("gap_latency", 64'(code0), 64'd8192);
    cyc(1'b0, 1'b0, 1'b0);
    chk("gap_code", 64'(code0), 64'd8196);

    // Reset mid-window discards the partial window
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    cyc(1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("midrst_nowin", 64'(code0), 64'd8192);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("midrst_win", 64'(code0), 64'd8196);

    // Randomised segments with biased directions and sparse resets
    for (int seg = 0; seg < 20; seg++) begin
      mode = $urandom_range(0, 3);
      for (int i = 0; i < 200; i++) begin
        r_e = ($urandom_range(0, 9) != 0);
        case (mode)
          1: begin r_u = 1'b1; r_d = ($urandom_range(0, 15) == 0); end
          2: begin r_d = 1'b1; r_u = ($urandom_range(0, 15) == 0); end
          default: begin r_u = 1'($urandom_range(0, 1)); r_d = 1'($urandom_range(0, 1)); end
        endcase
        rst = ($urandom_range(0, 499) == 0);
        cyc(r_e, r_u, r_d);
      end
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
